sv_lcd_persist: RTL and testbench
=================================

# sv_lcd_persist

Downstream video stage for the SuperVision core that emulates the slow LCD response of the original handheld. It consumes the 2-bit pixel stream and blanking/sync signals produced by the LCD controller and blends each pixel with its value from the previous frame, held in a frame-sized persistence RAM. It emits an 8-bit luminance stream, with sync delayed to match, to the scaler/video output.

## Interface
Parameters:
- H_ACTIVE, 160, active pixels per line
- V_ACTIVE, 160, active lines per frame
- DECAY_SHIFT, 2, blend step = difference >> DECAY_SHIFT (range 0..7)

Ports:
- clk_sys  in  1  system clock
- reset  in  1  reset, synchronous, active-high; clock clk_sys
- pix_ce  in  1  pixel strobe from LCD controller, spaced ≥3 clk_sys apart
- pixel  in  2  pixel darkness (0 lightest, 3 darkest)
- hblank, vblank, hsync, vsync  in  1 each  LCD timing
- enable  in  1  1 = blend, 0 = passthrough
- out_ce  out  1  output pixel strobe
- out_lum  out  8  output luminance (255 = white)
- out_hblank, out_vblank, out_hsync, out_vsync  out  1 each  delayed timing
- busy  out  1  high while the RAM clear runs

## Operation
- Target map: pixel 0→255, 1→170, 2→85, 3→0.
- Position counters x (8b), y (8b):
  - x clears while hblank and increments after each active pix_ce.
  - y clears while vblank and increments on the hblank rising edge if the line had ≥1 active pixel.
- Active pixel: pix_ce & ~hblank & ~vblank & x<H_ACTIVE & y<V_ACTIVE. Address = y*H_ACTIVE + x (15b).
- Blend (enable=1, RUN): d = target − old (9b signed); step = d >>> DECAY_SHIFT. If d≠0 and step=0, step = sign(d)·1. new = old + step, clamped to 0..255. The result always converges to the target; overshoot is impossible.
- Passthrough (enable=0): new = target.
- In both modes new is written back to the same address, so re-enabling blending causes no flash.
- Non-active pix_ce (out of range): out_lum = target, no RAM access.
- FSM, two states:
  - CLEAR: entered on reset. Walks addresses 0..H_ACTIVE·V_ACTIVE−1, writing 255 one per clk_sys. busy=1. Pixels pass through as targets with no RAM write.
  - RUN: entered after the last clear write. busy=0.
  - A reset mid-CLEAR or mid-RUN restarts CLEAR at address 0.

## Timing
- Stage 0, on pix_ce: latch target and address; issue RAM read.
- Stage 1, +1 clk: read data valid; compute new.
- Stage 2, +2 clk: out_lum/out_ce registered; RAM write of new.
- out_ce pulses exactly 2 clk_sys after pix_ce, one cycle wide. out_lum holds until the next out_ce.
- All four timing outputs are a 2-clk shift of the inputs, so they stay aligned with out_lum.
- Reset values: out_ce 0, out_lum 0, timing outputs 0, busy 1, x=y=0, clear address 0.
- Clear completes in 25600 clk_sys, less than one frame at the nominal rate.
- RAM contents are not reset except by the CLEAR walk.
- pix_ce spacing <3 clk is out of contract; write-before-read on the same address is not required.

## Structure
- Shared package sv_video_pkg: the target-luminance map constant, H_ACTIVE/V_ACTIVE defaults, and the FSM state enum (CLEAR, RUN).
- One sub-module, sv_persist_ram: single-clock RAM with 15-bit address, 8-bit data, 1-cycle registered read, and one read port plus one write port. The write port is muxed between the clear engine and stage-2 writeback.
- Blend arithmetic, counters, FSM and delay lines live in the top.

## Test plan
- Reset, then count clocks: busy high 25600 clk_sys then low; a read-back of addresses 0 and 25599 gives 255.
- RUN, enable=1, DECAY_SHIFT=2, pixel 3 at (0,0) for consecutive frames: out_lum 191, 143, 107, 80, … reaching 0 and staying 0.
- Then pixel 0 at the same spot: out_lum rises monotonically back to 255 and holds. No value exceeds 255 or goes below 0.
- enable=0, pixel 2 anywhere: out_lum=85 on the first frame. Set enable=1 with pixel 2 held: out_lum stays 85.
- pix_ce at x=160 or y=160: out_lum = target, no RAM write (RAM unchanged at address y*160+x).
- Assert reset during frame 2 of the decay test: outputs go to reset values next clk, CLEAR restarts at 0, and the first RUN frame after the clear starts from 255.

Source files
------------

// File: rtl/sv_video_pkg.sv
// Shared video definitions for the SuperVision LCD path: active-area defaults,
// the pixel-to-luminance target map and the persistence FSM states.
package sv_video_pkg;

  localparam int H_ACTIVE_DEF = 160;
  localparam int V_ACTIVE_DEF = 160;

  // Byte n holds the luminance for pixel code n (0 lightest .. 3 darkest).
  localparam logic [31:0] LUM_MAP = {8'd0, 8'd85, 8'd170, 8'd255};

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } persist_state_t;

  function automatic logic [7:0] lum_target(input logic [1:0] pix);
    return LUM_MAP[{pix, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/sv_lcd_persist_if.sv
// Pixel stream into and luminance stream out of the LCD persistence stage.
interface sv_lcd_persist_if;

  logic       pix_ce;
  logic [1:0] pixel;
  logic       hblank;
  logic       vblank;
  logic       hsync;
  logic       vsync;
  logic       enable;
  logic       out_ce;
  logic [7:0] out_lum;
  logic       out_hblank;
  logic       out_vblank;
  logic       out_hsync;
  logic       out_vsync;
  logic       busy;

  modport master (
    output pix_ce, pixel, hblank, vblank, hsync, vsync, enable,
    input  out_ce, out_lum, out_hblank, out_vblank, out_hsync, out_vsync, busy
  );

  modport slave (
    input  pix_ce, pixel, hblank, vblank, hsync, vsync, enable,
    output out_ce, out_lum, out_hblank, out_vblank, out_hsync, out_vsync, busy
  );

endinterface

// File: rtl/sv_persist_ram.sv
// Frame-sized persistence store: one write port, one read port with a
// single-cycle registered read, intended to map onto block RAM.
module sv_persist_ram #(
  parameter int DEPTH = 25600,
  parameter int AW    = 15,
  parameter int DW    = 8
) (
  input  logic          clk_sys,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk_sys) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/sv_lcd_persist.sv
// LCD persistence emulation: blends each active pixel toward its target
// luminance starting from last frame's value, with sync delayed to match.
module sv_lcd_persist
  import sv_video_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int DECAY_SHIFT = 2
) (
  input logic                clk_sys,
  input logic                reset,
  sv_lcd_persist_if.slave    vid
);

  localparam int          DEPTH    = H_ACTIVE * V_ACTIVE;
  localparam logic [7:0]  H_LIM    = 8'(H_ACTIVE);
  localparam logic [7:0]  V_LIM    = 8'(V_ACTIVE);
  localparam logic [14:0] H_W      = 15'(H_ACTIVE);
  localparam logic [14:0] CLR_LAST = 15'(DEPTH - 1);

  persist_state_t state_reg, state_next;
  logic [14:0]    clr_addr_reg;
  logic           busy;
  logic           clr_we;

  logic [7:0]     x_reg, y_reg;
  logic           hblank_d_reg;
  logic           line_px_reg;
  logic           hblank_rise;
  logic           pix_active;
  logic [14:0]    pix_addr;
  logic           rd_en;
  logic [7:0]     ram_rd_data;

  logic           s1_valid_reg, s1_wb_reg, s1_blend_reg;
  logic [7:0]     s1_target_reg;
  logic [14:0]    s1_addr_reg;

  logic signed [8:0] diff;
  logic signed [8:0] step;
  logic signed [9:0] sum;
  logic [7:0]        blend_lum;
  logic [7:0]        new_lum;

  logic           out_ce_reg;
  logic [7:0]     out_lum_reg;
  logic           wb_we_reg;
  logic [14:0]    wb_addr_reg;

  logic           ram_we;
  logic [14:0]    ram_wr_addr;
  logic [7:0]     ram_wr_data;

  logic [3:0]     tim_in, tim_d1_reg, tim_d2_reg;

  // FSM: state register / next state / outputs
  always_ff @(posedge clk_sys) begin
    if (reset) state_reg <= CLEAR;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      CLEAR:   if (clr_addr_reg == CLR_LAST) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = CLEAR;
    endcase
  end

  always_comb begin
    busy   = (state_reg == CLEAR);
    clr_we = (state_reg == CLEAR) & ~reset;
  end

  always_ff @(posedge clk_sys) begin
    if (reset)
      clr_addr_reg <= '0;
    else if (state_reg == CLEAR && clr_addr_reg != CLR_LAST)
      clr_addr_reg <= clr_addr_reg + 15'd1;
  end

  // Screen position; x saturates at H_ACTIVE because only active pixels advance it.
  assign hblank_rise = vid.hblank & ~hblank_d_reg;
  assign pix_active  = vid.pix_ce & ~vid.hblank & ~vid.vblank & (x_reg < H_LIM) & (y_reg < V_LIM);
  assign pix_addr    = 15'(y_reg) * H_W + 15'(x_reg);
  assign rd_en       = pix_active & (state_reg == RUN);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      x_reg        <= '0;
      y_reg        <= '0;
      hblank_d_reg <= 1'b0;
      line_px_reg  <= 1'b0;
    end else begin
      hblank_d_reg <= vid.hblank;
      if (vid.hblank)      x_reg <= '0;
      else if (pix_active) x_reg <= x_reg + 8'd1;
      if (vid.vblank)                      y_reg <= '0;
      else if (hblank_rise && line_px_reg) y_reg <= y_reg + 8'd1;
      if (vid.vblank || hblank_rise) line_px_reg <= 1'b0;
      else if (pix_active)           line_px_reg <= 1'b1;
    end
  end

  // Stage 0 -> 1: capture the pixel while the RAM fetches last frame's value.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      s1_valid_reg  <= 1'b0;
      s1_wb_reg     <= 1'b0;
      s1_blend_reg  <= 1'b0;
      s1_target_reg <= '0;
      s1_addr_reg   <= '0;
    end else begin
      s1_valid_reg <= vid.pix_ce;
      s1_wb_reg    <= rd_en;
      s1_blend_reg <= vid.enable;
      if (vid.pix_ce) begin
        s1_target_reg <= lum_target(vid.pixel);
        s1_addr_reg   <= pix_addr;
      end
    end
  end

  // A step that shifts to zero still moves one unit, so the value always lands on target.
  always_comb begin
    diff = $signed({1'b0, s1_target_reg}) - $signed({1'b0, ram_rd_data});
    step = diff >>> DECAY_SHIFT;
    if (diff != 9'sd0 && step == 9'sd0)
      step = diff[8] ? -9'sd1 : 9'sd1;
    sum = $signed({2'b00, ram_rd_data}) + $signed({step[8], step});
    if (sum < 10'sd0)        blend_lum = 8'd0;
    else if (sum > 10'sd255) blend_lum = 8'd255;
    else                     blend_lum = sum[7:0];
    if (s1_wb_reg && s1_blend_reg) new_lum = blend_lum;
    else                           new_lum = s1_target_reg;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      out_ce_reg  <= 1'b0;
      out_lum_reg <= '0;
      wb_we_reg   <= 1'b0;
      wb_addr_reg <= '0;
    end else begin
      out_ce_reg <= s1_valid_reg;
      wb_we_reg  <= s1_valid_reg & s1_wb_reg;
      if (s1_valid_reg) begin
        out_lum_reg <= new_lum;
        wb_addr_reg <= s1_addr_reg;
      end
    end
  end

  // Writeback only exists for pixels captured in RUN, so it never collides with the clear walk.
  assign ram_we      = clr_we | wb_we_reg;
  assign ram_wr_addr = clr_we ? clr_addr_reg : wb_addr_reg;
  assign ram_wr_data = clr_we ? 8'hFF : out_lum_reg;

  sv_persist_ram #(
    .DEPTH (DEPTH),
    .AW    (15),
    .DW    (8)
  ) u_ram (
    .clk_sys (clk_sys),
    .rd_en   (rd_en),
    .rd_addr (pix_addr),
    .rd_data (ram_rd_data),
    .wr_en   (ram_we),
    .wr_addr (ram_wr_addr),
    .wr_data (ram_wr_data)
  );

  assign tim_in = {vid.vsync, vid.hsync, vid.vblank, vid.hblank};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_tim_delay
      always_ff @(posedge clk_sys) begin
        if (reset) begin
          tim_d1_reg[gi] <= 1'b0;
          tim_d2_reg[gi] <= 1'b0;
        end else begin
          tim_d1_reg[gi] <= tim_in[gi];
          tim_d2_reg[gi] <= tim_d1_reg[gi];
        end
      end
    end
  endgenerate

  assign vid.out_ce     = out_ce_reg;
  assign vid.out_lum    = out_lum_reg;
  assign vid.out_hblank = tim_d2_reg[0];
  assign vid.out_vblank = tim_d2_reg[1];
  assign vid.out_hsync  = tim_d2_reg[2];
  assign vid.out_vsync  = tim_d2_reg[3];
  assign vid.busy       = busy;

endmodule

// File: tb/tb_sv_lcd_persist.sv
// Directed bench for sv_lcd_persist: clear timing, decay/recovery tables,
// passthrough, out-of-range pixels and reset during operation.
module tb_sv_lcd_persist;

  logic clk_sys = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cnt;
  logic [7:0] lum;
  logic       ce;

  // Hand-computed blend sequences for DECAY_SHIFT = 2.
  localparam logic [7:0] DECAY_EXP [18] = '{
    8'd191, 8'd143, 8'd107, 8'd80, 8'd60, 8'd45, 8'd33, 8'd24, 8'd18,
    8'd13, 8'd9, 8'd6, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0, 8'd0};
  localparam logic [7:0] RISE_EXP [21] = '{
    8'd63, 8'd111, 8'd147, 8'd174, 8'd194, 8'd209, 8'd220, 8'd228, 8'd234,
    8'd239, 8'd243, 8'd246, 8'd248, 8'd249, 8'd250, 8'd251, 8'd252, 8'd253,
    8'd254, 8'd255, 8'd255};

  sv_lcd_persist_if vif();

  sv_lcd_persist #(
    .H_ACTIVE    (160),
    .V_ACTIVE    (160),
    .DECAY_SHIFT (2)
  ) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .vid     (vif.slave)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Blank pulse then one pixel at (0,0); checks strobe timing, sync alignment and value.
  task automatic frame_pix(input logic [1:0] p, input logic [7:0] exp, input string tag);
    vif.vblank = 1'b1; vif.hblank = 1'b1; vif.vsync = 1'b1; vif.hsync = 1'b1;
    @(negedge clk_sys);
    vif.vblank = 1'b0; vif.hblank = 1'b0; vif.vsync = 1'b0; vif.hsync = 1'b0;
    vif.pix_ce = 1'b1; vif.pixel = p;
    @(negedge clk_sys);
    vif.pix_ce = 1'b0;
    chk({tag, "_ce_early"}, 32'(vif.out_ce), 0);
    chk({tag, "_vblank_dly"}, 32'(vif.out_vblank), 1);
    chk({tag, "_vsync_dly"}, 32'(vif.out_vsync), 1);
    @(negedge clk_sys);
    chk({tag, "_ce"}, 32'(vif.out_ce), 1);
    chk({tag, "_lum"}, 32'(vif.out_lum), 32'(exp));
    @(negedge clk_sys);
    chk({tag, "_ce_off"}, 32'(vif.out_ce), 0);
    chk({tag, "_lum_hold"}, 32'(vif.out_lum), 32'(exp));
    $display("frame %s pixel %0d lum %0d expected %0d", tag, p, vif.out_lum, exp);
  endtask

  // One pixel strobe; returns the output seen two clocks later, spaced 3 clocks.
  task automatic pix_out(input logic [1:0] p, output logic [7:0] l, output logic c);
    vif.pix_ce = 1'b1; vif.pixel = p;
    @(negedge clk_sys);
    vif.pix_ce = 1'b0;
    @(negedge clk_sys);
    l = vif.out_lum;
    c = vif.out_ce;
    @(negedge clk_sys);
  endtask

  task automatic hblank_pulse();
    vif.hblank = 1'b1;
    @(negedge clk_sys);
    vif.hblank = 1'b0;
  endtask

  task automatic count_clear(input string tag);
    cnt = 0;
    while (vif.busy === 1'b1 && cnt < 30000) begin
      cnt++;
      @(negedge clk_sys);
    end
    chk(tag, 32'(cnt), 25600);
    $display("clear %s busy cycles %0d", tag, cnt);
  endtask

  initial begin
    reset = 1'b1;
    vif.pix_ce = 1'b0; vif.pixel = 2'd0; vif.enable = 1'b1;
    vif.hblank = 1'b0; vif.vblank = 1'b0; vif.hsync = 1'b0; vif.vsync = 1'b0;
    repeat (3) @(negedge clk_sys);
    chk("rst_out_ce", 32'(vif.out_ce), 0);
    chk("rst_out_lum", 32'(vif.out_lum), 0);
    chk("rst_out_hblank", 32'(vif.out_hblank), 0);
    chk("rst_out_vblank", 32'(vif.out_vblank), 0);
    chk("rst_out_hsync", 32'(vif.out_hsync), 0);
    chk("rst_out_vsync", 32'(vif.out_vsync), 0);
    chk("rst_busy", 32'(vif.busy), 1);
    $display("reset ce %0d lum %0d busy %0d", vif.out_ce, vif.out_lum, vif.busy);

    reset = 1'b0;
    count_clear("clear_cycles");
    chk("ram_addr0", 32'(dut.u_ram.mem[0]), 255);
    chk("ram_addr25599", 32'(dut.u_ram.mem[25599]), 255);

    for (int i = 0; i < 18; i++) frame_pix(2'd3, DECAY_EXP[i], $sformatf("decay%0d", i));
    for (int i = 0; i < 21; i++) frame_pix(2'd0, RISE_EXP[i], $sformatf("rise%0d", i));

    vif.enable = 1'b0;
    frame_pix(2'd2, 8'd85, "passthru");
    vif.enable = 1'b1;
    frame_pix(2'd2, 8'd85, "reenable");

    // Line 0 with 161 strobes: the last one sits at x=160 and must not touch RAM.
    vif.vblank = 1'b1; vif.hblank = 1'b1;
    @(negedge clk_sys);
    vif.vblank = 1'b0; vif.hblank = 1'b0;
    for (int i = 0; i < 161; i++) begin
      pix_out(2'd3, lum, ce);
      if (i == 0)   chk("line_x0_lum", 32'(lum), 63);
      if (i == 159) chk("line_x159_lum", 32'(lum), 191);
      if (i == 160) begin
        chk("x160_lum", 32'(lum), 0);
        chk("x160_ce", 32'(ce), 1);
        $display("pixel x160 lum %0d ce %0d", lum, ce);
      end
    end
    chk("ram_x159_written", 32'(dut.u_ram.mem[159]), 191);
    chk("ram_x160_untouched", 32'(dut.u_ram.mem[160]), 255);

    hblank_pulse();
    pix_out(2'd0, lum, ce);
    chk("y1_x0_lum", 32'(lum), 255);
    $display("pixel y1 x0 lum %0d", lum);
    for (int k = 2; k < 160; k++) begin
      hblank_pulse();
      pix_out(2'd0, lum, ce);
    end
    hblank_pulse();
    pix_out(2'd1, lum, ce);
    chk("y160_lum", 32'(lum), 170);
    chk("y160_ce", 32'(ce), 1);
    $display("pixel y160 lum %0d ce %0d", lum, ce);

    frame_pix(2'd3, 8'd47, "pre_reset");

    // Reset while a pixel is in flight.
    vif.vblank = 1'b1; vif.hblank = 1'b1;
    @(negedge clk_sys);
    vif.vblank = 1'b0; vif.hblank = 1'b0; vif.pix_ce = 1'b1; vif.pixel = 2'd3;
    @(negedge clk_sys);
    vif.pix_ce = 1'b0;
    reset = 1'b1;
    @(negedge clk_sys);
    chk("midrst_out_ce", 32'(vif.out_ce), 0);
    chk("midrst_out_lum", 32'(vif.out_lum), 0);
    chk("midrst_busy", 32'(vif.busy), 1);
    $display("mid-run reset ce %0d lum %0d busy %0d", vif.out_ce, vif.out_lum, vif.busy);
    @(negedge clk_sys);
    reset = 1'b0;
    count_clear("reclear_cycles");
    frame_pix(2'd3, 8'd191, "post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
